ifns_code_rx_buffer_29: RTL and testbench
=========================================

// Module: ifns_code_rx_buffer_29
// PURPOSE
//   Receive-side buffer in front of the 29-bit IFNS decoder. Captures 29-bit IFNS codewords
//   from the link when link_valid is high and stores them in a small FIFO. Presents them in
//   order to the decoder stage through a valid/ready handshake.
//   Counts codewords dropped because the buffer was full, so that link overruns are visible
//   to status logic.
// PARAMETERS
//   CODE_W   29  codeword width; bits indexed [CODE_W:1] to match the decoder's codein
//   DEPTH    4   FIFO entries; must be a power of 2 and at least 2
//   CNT_W    8   width of the drop counter
// PORTS
//   clock        in   1          single clock; all state changes on its rising edge
//   rst_n        in   1          asynchronous, active-low reset
//   flush        in   1          synchronous clear of FIFO contents (counter kept)
//   link_valid   in   1          link_code carries a codeword this cycle
//   link_code    in   CODE_W     incoming codeword, [CODE_W:1]
//   code_valid   out  1          code_out holds a buffered codeword
//   code_ready   in   1          decoder stage accepts code_out this cycle
//   code_out     out  CODE_W     oldest buffered codeword, [CODE_W:1]; feeds decoder codein
//   level        out  log2(DEPTH)+1  number of stored entries, 0..DEPTH
//   full         out  1          level == DEPTH
//   drop_cnt     out  CNT_W      dropped codewords; saturates at all-ones
//   drop_clr     in   1          synchronous clear of drop_cnt
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous):
//     - pointers, level and drop_cnt go to 0; code_valid=0; full=0.
//     - code_out goes to 0. FIFO RAM contents are not reset.
//   - Write: occurs when link_valid=1 and (full=0, or a read happens in the same cycle).
//     - The codeword is stored at wr_ptr and wr_ptr advances modulo DEPTH.
//   - Drop: link_valid=1 while full=1 and no read in the same cycle.
//     - The codeword is discarded; drop_cnt increments by 1 and holds at 2^CNT_W-1.
//   - Read: occurs when code_valid=1 and code_ready=1; rd_ptr advances modulo DEPTH.
//   - code_valid = (level != 0).
//   - code_out is the entry at rd_ptr. It is driven from a register/mux so that it is stable
//     while code_valid=1 and code_ready=0.
//   - Latency: a codeword written at edge N is visible on code_out with code_valid=1 after
//     edge N when the FIFO was empty. There is no combinational path from link to code_out.
//   - Simultaneous read and write: level is unchanged. This holds when full (the write uses
//     the freed slot, no drop) and when level==1 (code_out moves to the new word at the next edge).
//   - Pointer wrap: pointers are log2(DEPTH) bits wide. level distinguishes full from empty.
//   - flush=1: at the next edge, rd_ptr=wr_ptr=0 and level=0, so code_valid=0.
//     - flush has priority over read and write in that cycle.
//     - A link word arriving in the flush cycle is discarded and is not counted as a drop.
//   - drop_clr=1: drop_cnt=0 at the next edge. It overrides an increment in the same cycle.
//   - No code checking is done here; words pass through bit-exact, with bit i in stays bit i out.
//   - Reset asserted mid-transfer: all buffered words are lost. code_valid drops
//     immediately (asynchronously).
// TESTING
//   1. Reset, then one write of 29'h1555_5555 with code_ready=1:
//      -> code_valid=1 one cycle later with code_out=29'h1555_5555, then 0; level back to 0.
//   2. Write 4 words 1,2,3,4 with code_ready=0:
//      -> full=1, level=4; releasing code_ready gives output order 1,2,3,4 and drop_cnt=0.
//   3. While full, 3 more writes with code_ready=0:
//      -> drop_cnt=3, contents still 1..4. Then drop_clr -> drop_cnt=0.
//   4. Full, with link_valid=1 and code_ready=1 in the same cycle:
//      -> level stays 4, no drop, the new word is output last.
//   5. Hold drop_cnt at 255 (CNT_W=8) and keep overflowing -> drop_cnt remains 255.
//   6. Write 2 words, then flush with link_valid=1:
//      -> level=0, code_valid=0, drop_cnt unchanged.
//      Then apply rst_n low mid-stream -> all outputs are 0 immediately.

Source files
------------

// File: rtl/ifns_code_rx_buffer_29.sv
// Receive-side codeword FIFO in front of the 29-bit IFNS decoder.
// Buffers link codewords, hands them out in order over valid/ready and counts overrun drops.
module ifns_code_rx_buffer_29 #(
    parameter int CODE_W = 29,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      link_valid,
    input  logic [CODE_W:1]           link_code,
    output logic                      code_valid,
    input  logic                      code_ready,
    output logic [CODE_W:1]           code_out,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      drop_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CODE_W:1]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               rd_en, wr_en, drop_en;

    assign code_valid = (level_q != '0);
    assign full       = (level_q == LVL_W'(DEPTH));
    assign level      = level_q;
    assign drop_cnt   = drop_cnt_q;
    // Gating with code_valid keeps code_out at zero after reset/flush, since the RAM is not cleared.
    assign code_out   = code_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        rd_en   = code_valid && code_ready && !flush;
        // A simultaneous read frees the slot, so a full buffer still accepts the word.
        wr_en   = link_valid && !flush && (!full || rd_en);
        drop_en = link_valid && !flush && full && !rd_en;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        if (drop_clr)
            drop_cnt_d = '0;
        else if (drop_en && (drop_cnt_q != {CNT_W{1'b1}}))
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= link_code;
    end

endmodule

// File: tb/tb_ifns_code_rx_buffer_29.sv
// Self-checking bench for ifns_code_rx_buffer_29: queue scoreboard for data order,
// an independent occupancy/drop model, plus directed checks of the boundary cases.
module tb_ifns_code_rx_buffer_29;

    localparam int CODE_W = 29;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              link_valid = 1'b0;
    logic [CODE_W:1]   link_code = '0;
    logic              code_valid;
    logic              code_ready = 1'b0;
    logic [CODE_W:1]   code_out;
    logic [$clog2(DEPTH):0] level;
    logic              full;
    logic [CNT_W-1:0]  drop_cnt;
    logic              drop_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [CODE_W:1] sbq [$];
    int mlevel = 0;
    int mdrop  = 0;

    ifns_code_rx_buffer_29 #(.CODE_W(CODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .flush      (flush),
        .link_valid (link_valid),
        .link_code  (link_code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_out   (code_out),
        .level      (level),
        .full       (full),
        .drop_cnt   (drop_cnt),
        .drop_clr   (drop_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [CODE_W:1] code, input logic rdy);
        link_valid = lv;
        link_code  = code;
        code_ready = rdy;
    endtask

    // Model runs mid-cycle: compares current state, then predicts the effect of the next edge.
    always @(negedge clock) begin
        logic rd;
        if (!rst_n) begin
            sbq.delete();
            mlevel = 0;
            mdrop  = 0;
        end else begin
            check("sb_level", level, mlevel);
            check("sb_valid", code_valid, mlevel != 0);
            check("sb_full", full, mlevel == DEPTH);
            check("sb_drop", drop_cnt, mdrop);
            rd = (mlevel != 0) && code_ready && !flush;
            if (rd) begin
                if (sbq.size() == 0) check("sb_underflow", 1, 0);
                else check("sb_code_out", code_out, sbq[0]);
            end
            if (flush) begin
                sbq.delete();
            end else begin
                if (rd) void'(sbq.pop_front());
                if (link_valid) begin
                    if (mlevel < DEPTH || rd) sbq.push_back(link_code);
                    else if (mdrop != 255) mdrop++;
                end
            end
            if (drop_clr) mdrop = 0;
            mlevel = sbq.size();
        end
    end

    initial begin
        #2;
        check("rst_valid", code_valid, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_code_out", code_out, 0);
        step();
        rst_n = 1'b1;
        step();

        // single word passes straight through
        drive(1'b1, 29'h1555_5555, 1'b1);
        step();
        drive(1'b0, '0, 1'b1);
        check("t1_valid", code_valid, 1);
        check("t1_out", code_out, 29'h1555_5555);
        step();
        check("t1_valid_after", code_valid, 0);
        check("t1_level_after", level, 0);

        // fill to full
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, CODE_W'(i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        check("t2_full", full, 1);
        check("t2_level", level, 4);
        check("t2_drop", drop_cnt, 0);

        // overflow while full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, CODE_W'(100 + i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        check("t3_drop", drop_cnt, 3);
        check("t3_level", level, 4);
        check("t3_head", code_out, 1);
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        check("t3_drop_clr", drop_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            step();
        end
        check("t2_drained", level, 0);

        // full with simultaneous read and write
        for (int i = 11; i <= 14; i++) begin
            drive(1'b1, CODE_W'(i), 1'b0);
            step();
        end
        drive(1'b1, CODE_W'(15), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check("t4_level", level, 4);
        check("t4_drop", drop_cnt, 0);
        check("t4_head", code_out, 12);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            step();
        end
        check("t4_drained", level, 0);

        // simultaneous read and write at level 1
        drive(1'b1, CODE_W'(21), 1'b0);
        step();
        drive(1'b1, CODE_W'(22), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check("lvl1_level", level, 1);
        check("lvl1_out", code_out, 22);
        drive(1'b0, '0, 1'b1);
        step();

        // drop counter saturation
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, CODE_W'(30 + i), 1'b0);
            step();
        end
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, CODE_W'($urandom), 1'b0);
            step();
        end
        check("t5_sat", drop_cnt, 255);
        for (int i = 0; i < 5; i++) step();
        check("t5_hold", drop_cnt, 255);
        drop_clr = 1'b1;
        drive(1'b0, '0, 1'b0);
        step();
        drop_clr = 1'b0;
        check("t5_clr", drop_cnt, 0);
        drive(1'b1, CODE_W'(77), 1'b0);
        step();
        step();
        drive(1'b0, '0, 1'b0);
        check("t6_drop_pre", drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            step();
        end

        // flush with a link word in the same cycle
        drive(1'b1, CODE_W'(41), 1'b0);
        step();
        drive(1'b1, CODE_W'(42), 1'b0);
        step();
        drive(1'b1, CODE_W'(43), 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        check("t6_level", level, 0);
        check("t6_valid", code_valid, 0);
        check("t6_drop", drop_cnt, 2);
        check("t6_code_out", code_out, 0);

        // asynchronous reset mid-stream
        for (int i = 51; i <= 53; i++) begin
            drive(1'b1, CODE_W'(i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        check("t6_pre_rst_level", level, 3);
        rst_n = 1'b0;
        #1;
        check("arst_valid", code_valid, 0);
        check("arst_level", level, 0);
        check("arst_full", full, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_code_out", code_out, 0);
        step();
        rst_n = 1'b1;
        step();

        // buffer still works after reset
        drive(1'b1, CODE_W'(29'h0AAA_AAAA), 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        check("post_rst_out", code_out, 29'h0AAA_AAAA);
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        step();
        check("end_empty", level, 0);
        check("end_sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
